// File: rtl/pipe_alu.sv
// Single-issue ALU: one-cycle ops land straight in the result register, MUL runs
// a bit-serial shift-add for W cycles; the result is held until OUT_READY.
module pipe_alu #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  input  logic [3:0]   OP,
  input  logic         C_IN,
  input  logic         S_IN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         C_OUT,
  output logic         S_OUT,
  output logic         ZERO,
  output logic         NEG,
  output logic         OVF,
  output logic         ILLEGAL
);

  localparam int LG = $clog2(W);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         s;
    logic         z;
    logic         n;
    logic         v;
    logic         ill;
  } res_t;

  // Single-cycle ops; MUL lands in the empty branch and is never loaded from here.
  // Shift index arithmetic is LG bits wide so rotates wrap modulo W for free.
  function automatic res_t alu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] op, input logic ci, input logic si);
    res_t         r;
    logic [W:0]   sum;
    logic [W-1:0] bx;
    logic [LG-1:0] amt;
    logic [LG-1:0] idx;
    logic         fill;
    r    = '0;
    sum  = '0;
    bx   = b;
    amt  = b[LG-1:0];
    idx  = '0;
    fill = si;
    case (op)
      OP_ADD, OP_SUB: begin
        bx    = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, ci};
        r.out = sum[W-1:0];
        r.c   = sum[W];
        r.v   = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SHL, OP_ROL: begin
        for (int i = 0; i < W; i++) begin
          idx      = LG'(i) - amt;
          r.out[i] = (op == OP_ROL || i >= int'(amt)) ? a[idx] : si;
        end
        idx = LG'(0) - amt;
        r.s = (amt != '0) && a[idx];
      end
      OP_SHR, OP_ASR, OP_ROR: begin
        fill = (op == OP_ASR) ? a[W-1] : si;
        for (int i = 0; i < W; i++) begin
          idx      = LG'(i) + amt;
          r.out[i] = (op == OP_ROR || i + int'(amt) < W) ? a[idx] : fill;
        end
        idx = amt - LG'(1);
        r.s = (amt != '0) && a[idx];
      end
      OP_XOR:  r.out = a ^ b;
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_PASS: r.out = a;
      OP_MUL:  r.out = '0;
      default: r.ill = 1'b1;
    endcase
    r.z = (r.out == '0);
    r.n = r.out[W-1];
    return r;
  endfunction

  logic [1:0]     state;
  logic           accept;
  logic           is_mul;
  res_t           alu_res;
  res_t           mul_res;
  res_t           res_p1;
  logic [W-1:0]   out_hi_p1;
  logic           vld_p1;
  logic [W-1:0]   mcand_p0;
  logic [2*W-1:0] prod_p0;
  logic [2*W-1:0] prod_nxt;
  logic [W:0]     madd;
  logic [LG-1:0]  cnt_p0;

  assign IN_READY = (state == IDLE) || (state == HOLD && OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign is_mul   = (OP == OP_MUL);
  assign alu_res  = alu_eval(INPUTA, INPUTB, OP, C_IN, S_IN);

  // Multiplier iteration: conditionally add the multiplicand to the high half, shift right.
  always_comb begin
    madd     = {1'b0, prod_p0[2*W-1:W]} + (prod_p0[0] ? {1'b0, mcand_p0} : '0);
    prod_nxt = {madd, prod_p0[W-1:1]};
    mul_res     = '0;
    mul_res.out = prod_nxt[W-1:0];
    mul_res.z   = (prod_nxt == '0);
    mul_res.n   = prod_nxt[W-1];
  end

  always_ff @(posedge CLK) begin
    if (accept && is_mul) begin
      mcand_p0 <= INPUTA;
      prod_p0  <= {{W{1'b0}}, INPUTB};
    end else if (state == MUL_BUSY) begin
      prod_p0  <= prod_nxt;
    end
  end

  // Result stage: registered outputs and handshake state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      cnt_p0    <= '0;
      res_p1    <= '0;
      out_hi_p1 <= '0;
    end else if (accept) begin
      if (is_mul) begin
        state  <= MUL_BUSY;
        vld_p1 <= 1'b0;
        cnt_p0 <= '0;
      end else begin
        state     <= HOLD;
        vld_p1    <= 1'b1;
        res_p1    <= alu_res;
        out_hi_p1 <= '0;
      end
    end else begin
      case (state)
        MUL_BUSY: begin
          cnt_p0 <= cnt_p0 + LG'(1);
          if (cnt_p0 == LG'(W - 1)) begin
            state     <= HOLD;
            vld_p1    <= 1'b1;
            res_p1    <= mul_res;
            out_hi_p1 <= prod_nxt[2*W-1:W];
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign OUT_VALID = vld_p1;
  assign OUT       = res_p1.out;
  assign OUT_HI    = out_hi_p1;
  assign C_OUT     = res_p1.c;
  assign S_OUT     = res_p1.s;
  assign ZERO      = res_p1.z;
  assign NEG       = res_p1.n;
  assign OVF       = res_p1.v;
  assign ILLEGAL   = res_p1.ill;

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: accepted requests are modelled with plain
// integer arithmetic and queued; a monitor compares every presented result.
module tb_pipe_alu;

  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SHL = 4'd2,  OP_SHR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_PASS = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8,  OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_MUL = 4'd11;

  logic         CLK;
  logic         RESET;
  logic [W-1:0] INPUTA, INPUTB;
  logic [3:0]   OP;
  logic         C_IN, S_IN;
  logic         IN_VALID, IN_READY;
  logic         OUT_VALID, OUT_READY;
  logic [W-1:0] OUT, OUT_HI;
  logic         C_OUT, S_OUT, ZERO, NEG, OVF, ILLEGAL;

  pipe_alu #(.W(W)) dut (
    .CLK(CLK), .RESET(RESET), .INPUTA(INPUTA), .INPUTB(INPUTB), .OP(OP),
    .C_IN(C_IN), .S_IN(S_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .OUT_HI(OUT_HI),
    .C_OUT(C_OUT), .S_OUT(S_OUT), .ZERO(ZERO), .NEG(NEG), .OVF(OVF), .ILLEGAL(ILLEGAL)
  );

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         c, s, z, n, v, ill;
    int           first;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rdy_rand = 0;
  bit   seen = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic si);
    exp_t   e;
    longint ua, ub, sa, sb, ic, r, sr, msk, smax, smin;
    int     k;
    msk  = (longint'(1) << W) - 1;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(smax + 1);
    ua = longint'(a);
    ub = longint'(b);
    ic = longint'(ci);
    sa = (ua > smax) ? ua - msk - 1 : ua;
    sb = (ub > smax) ? ub - msk - 1 : ub;
    k  = int'(ub % longint'(W));
    r  = 0;
    sr = 0;
    e.out = '0; e.hi = '0; e.c = 0; e.s = 0; e.z = 0; e.n = 0; e.v = 0; e.ill = 0; e.first = 0;
    case (op)
      OP_ADD: begin
        r = ua + ub + ic;  sr = sa + sb + ic;
        e.c = r[W];  e.v = (sr > smax) || (sr < smin);
      end
      OP_SUB: begin
        r = ua + (msk - ub) + ic;  sr = sa - sb - 1 + ic;
        e.c = r[W];  e.v = (sr > smax) || (sr < smin);
      end
      OP_SHL: begin
        r = ((ua << k) | (si ? (longint'(1) << k) - 1 : longint'(0))) & msk;
        e.s = (k != 0) ? (((ua >> (W - k)) & 1) != 0) : 1'b0;
      end
      OP_SHR: begin
        r = (ua >> k) | (si ? (msk & ~(msk >> k)) : longint'(0));
        e.s = (k != 0) ? (((ua >> (k - 1)) & 1) != 0) : 1'b0;
      end
      OP_ASR: begin
        r = (sa >>> k) & msk;
        e.s = (k != 0) ? (((ua >> (k - 1)) & 1) != 0) : 1'b0;
      end
      OP_ROL: begin
        r = ((ua << k) | (ua >> (W - k))) & msk;
        e.s = (k != 0) ? (((ua >> (W - k)) & 1) != 0) : 1'b0;
      end
      OP_ROR: begin
        r = ((ua >> k) | (ua << (W - k))) & msk;
        e.s = (k != 0) ? (((ua >> (k - 1)) & 1) != 0) : 1'b0;
      end
      OP_XOR:  r = ua ^ ub;
      OP_AND:  r = ua & ub;
      OP_OR:   r = ua | ub;
      OP_PASS: r = ua;
      OP_MUL: begin
        r = ua * ub;
        e.hi = r[2*W-1:W];
      end
      default: begin
        r = 0;
        e.ill = 1;
      end
    endcase
    e.out = r[W-1:0];
    e.z   = (op == OP_MUL) ? (r == 0) : (e.out == '0);
    e.n   = e.out[W-1];
    return e;
  endfunction

  // Request side: model every accepted request; reset discards whatever is in flight.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      q.delete();
    end else if (IN_VALID && IN_READY) begin
      e = model(OP, INPUTA, INPUTB, C_IN, S_IN);
      e.first = cyc + ((OP == OP_MUL) ? W + 1 : 1);
      q.push_back(e);
    end
  end

  // Result side: compare every cycle a result is presented; pop when it is taken.
  always @(negedge CLK) begin
    if (RESET) begin
      seen = 0;
    end else if (OUT_VALID) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(OUT_VALID), 64'd0);
      end else begin
        if (!seen) begin
          chk("latency_cycle", 64'(cyc), 64'(q[0].first));
          seen = 1;
        end
        chk("out",     64'(OUT),     64'(q[0].out));
        chk("out_hi",  64'(OUT_HI),  64'(q[0].hi));
        chk("c_out",   64'(C_OUT),   64'(q[0].c));
        chk("s_out",   64'(S_OUT),   64'(q[0].s));
        chk("zero",    64'(ZERO),    64'(q[0].z));
        chk("neg",     64'(NEG),     64'(q[0].n));
        chk("ovf",     64'(OVF),     64'(q[0].v));
        chk("illegal", 64'(ILLEGAL), 64'(q[0].ill));
        if (!OUT_READY) chk("in_ready_while_held", 64'(IN_READY), 64'd0);
        if (OUT_READY) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rdy_rand) OUT_READY = ($urandom_range(0, 3) != 0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic si);
    int   n;
    logic acc;
    OP = op; INPUTA = a; INPUTB = b; C_IN = ci; S_IN = si; IN_VALID = 1;
    n = 0;
    acc = 0;
    while (!acc && n < 60) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end
    IN_VALID = 0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted after %0d cycles, required acceptance", op, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_out"},       64'(OUT),       64'd0);
    chk({tag, "_out_hi"},    64'(OUT_HI),    64'd0);
    chk({tag, "_flags"},     64'({C_OUT, S_OUT, ZERO, NEG, OVF, ILLEGAL}), 64'd0);
  endtask

  initial begin
    int wait_n;
    RESET = 1; IN_VALID = 1; OP = OP_ADD; INPUTA = 8'h12; INPUTB = 8'h34;
    C_IN = 0; S_IN = 0; OUT_READY = 1;

    // Reset holds even with a request pending.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    @(posedge CLK); #1;
    RESET = 0; IN_VALID = 0;
    @(negedge CLK);
    chk("in_ready_after_reset", 64'(IN_READY), 64'd1);
    step(1);

    issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    issue(OP_SUB, 8'h05, 8'h07, 1'b1, 1'b0);
    issue(OP_SUB, 8'h80, 8'h01, 1'b1, 1'b0);
    issue(OP_SHL, 8'h81, 8'h01, 1'b0, 1'b1);
    issue(OP_ASR, 8'h90, 8'h03, 1'b0, 1'b0);
    issue(OP_ROR, 8'h01, 8'h01, 1'b0, 1'b0);
    issue(OP_SHR, 8'hA5, 8'hF8, 1'b1, 1'b1);
    issue(OP_ROL, 8'h96, 8'h0D, 1'b0, 1'b0);
    issue(4'd14,  8'h5A, 8'hC3, 1'b1, 1'b1);
    issue(OP_MUL, 8'h00, 8'h37, 1'b0, 1'b0);
    step(W + 2);

    issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
    repeat (W) begin
      @(negedge CLK);
      chk("in_ready_mul_busy", 64'(IN_READY), 64'd0);
    end
    @(negedge CLK);
    chk("in_ready_mul_done", 64'(IN_READY), 64'd1);
    step(3);

    // Back-pressure, then same-cycle release with a new request.
    OUT_READY = 0;
    issue(OP_ADD, 8'h3C, 8'h4B, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
      chk("bp_in_ready",  64'(IN_READY),  64'd0);
    end
    @(posedge CLK); #1;
    OUT_READY = 1;
    issue(OP_XOR, 8'hF0, 8'h3C, 1'b0, 1'b0);
    step(3);

    // Reset during a multiply, then a reserved opcode.
    issue(OP_MUL, 8'hC7, 8'h5B, 1'b0, 1'b0);
    step(2);
    RESET = 1; IN_VALID = 1; OP = OP_ADD;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("mul_reset");
    @(posedge CLK); #1;
    RESET = 0; IN_VALID = 0;
    @(negedge CLK);
    chk("in_ready_after_mul_reset", 64'(IN_READY), 64'd1);
    step(1);
    issue(4'd13, 8'h77, 8'h21, 1'b1, 1'b1);
    step(2 * W + 4);

    // Randomized traffic with random back-pressure.
    rdy_rand = 1;
    repeat (300) begin
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step($urandom_range(0, 2));
    end
    rdy_rand = 0;
    OUT_READY = 1;

    wait_n = 0;
    while (q.size() != 0 && wait_n < 100) begin
      step(1);
      wait_n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
